// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU responder.
//   ALU_* : op-code values presented on alu_operation
//   state_t : control FSM states of the responder
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_DIV = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/alu_seq_step.sv
// Single-iteration datapath for the sequential ALU (purely combinational).
//   a   : multiplicand (mul, shifted left each step) / dividend-quotient shifter (div)
//   b   : multiplier (mul, shifted right each step) / divisor (div)
//   acc : product accumulator (mul) / partial remainder (div)
//   mul_*_next : state after one shift-add step
//   div_*_next : state after one restoring divide step
module alu_seq_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] mul_a_next,
  output logic [WIDTH-1:0] mul_b_next,
  output logic [WIDTH-1:0] mul_acc_next,
  output logic [WIDTH-1:0] div_quo_next,
  output logic [WIDTH-1:0] div_rem_next
);

  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] diff;

  always_comb begin
    mul_acc_next = b[0] ? acc + a : acc;
    mul_a_next   = a << 1;
    mul_b_next   = b >> 1;

    // Shifted partial remainder needs one extra bit; when it is >= the
    // divisor the true difference is < divisor, so WIDTH bits suffice.
    trial        = {acc, a[WIDTH-1]};
    ge           = trial >= {1'b0, b};
    diff         = trial[WIDTH-1:0] - b;
    div_rem_next = ge ? diff : trial[WIDTH-1:0];
    // Dividend bits leave at the top while quotient bits enter at the bottom.
    div_quo_next = {a[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/alu_seq_responder.sv
// Handshaked multi-cycle unsigned ALU: add/sub in one cycle, shift-add mul and
// restoring div one bit per cycle.
//   clk, rst_n              : clock, async active-low reset
//   req_valid/req_ready     : request handshake (a_in, b_in, alu_operation)
//   resp_valid/resp_ready   : response handshake (result, remainder, zero, err)
module alu_seq_responder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       alu_operation,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             zero,
  output logic             err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d, remainder_q, remainder_d;
  logic             zero_q, zero_d, err_q, err_d;

  logic [WIDTH-1:0] mul_a_next, mul_b_next, mul_acc_next;
  logic [WIDTH-1:0] div_quo_next, div_rem_next;
  logic [WIDTH-1:0] sum, dif;

  assign sum = a_in + b_in;
  assign dif = a_in - b_in;

  alu_seq_step #(.WIDTH(WIDTH)) u_step (
    .a            (a_q),
    .b            (b_q),
    .acc          (acc_q),
    .mul_a_next   (mul_a_next),
    .mul_b_next   (mul_b_next),
    .mul_acc_next (mul_acc_next),
    .div_quo_next (div_quo_next),
    .div_rem_next (div_rem_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    zero_d      = zero_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = '0;
          state_d = DONE;
          unique case (alu_operation)
            ALU_ADD: begin
              result_d = sum; remainder_d = '0; zero_d = (sum == '0); err_d = 1'b0;
            end
            ALU_SUB: begin
              result_d = dif; remainder_d = '0; zero_d = (dif == '0); err_d = 1'b0;
            end
            ALU_MUL: begin
              a_d = a_in; b_d = b_in; acc_d = '0; state_d = MUL;
            end
            ALU_DIV: begin
              if (b_in == '0) begin
                result_d = '1; remainder_d = a_in; zero_d = 1'b0; err_d = 1'b1;
              end else begin
                a_d = a_in; b_d = b_in; acc_d = '0; state_d = DIV;
              end
            end
            default: begin
              result_d = '0; remainder_d = '0; zero_d = 1'b1; err_d = 1'b1;
            end
          endcase
        end
      end
      MUL: begin
        a_d   = mul_a_next;
        b_d   = mul_b_next;
        acc_d = mul_acc_next;
        if (cnt_q == LAST) begin
          result_d    = mul_acc_next;
          remainder_d = '0;
          zero_d      = (mul_acc_next == '0);
          err_d       = 1'b0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DIV: begin
        a_d   = div_quo_next;
        acc_d = div_rem_next;
        if (cnt_q == LAST) begin
          result_d    = div_quo_next;
          remainder_d = div_rem_next;
          zero_d      = (div_quo_next == '0);
          err_d       = 1'b0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign result     = result_q;
  assign remainder  = remainder_q;
  assign zero       = zero_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_seq_responder.sv
// Scoreboard bench for alu_seq_responder: the driver pushes the expected
// response of each accepted request, the monitor pops and compares on every
// response handshake and checks that outputs hold steady under backpressure.
module tb_alu_seq_responder;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [2:0]   alu_operation = 3'b000;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] remainder;
  logic         zero;
  logic         err;

  alu_seq_responder #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .a_in          (a_in),
    .b_in          (b_in),
    .alu_operation (alu_operation),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .result        (result),
    .remainder     (remainder),
    .zero          (zero),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         z;
    logic         e;
    int unsigned  lat;   // edges from accept until resp_valid is seen
    int unsigned  acc;   // cycle stamp of the accept edge
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          in_resp = 1'b0;
  bit          hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    resp_ready = hold ? 1'b0 : ($urandom_range(0, 9) < 6);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain unsigned arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    exp_t e;
    e.res = '0; e.rem = '0; e.e = 1'b0; e.lat = 0; e.acc = 0;
    case (op)
      3'b010: e.res = a + b;
      3'b001: e.res = a - b;
      3'b100: begin e.res = a * b; e.lat = W; end
      3'b011: begin
        if (b == '0) begin
          e.res = '1; e.rem = a; e.e = 1'b1;
        end else begin
          e.res = a / b; e.rem = a % b; e.lat = W;
        end
      end
      default: e.e = 1'b1;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    int unsigned waited = 0;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; a_in = a; b_in = b; alu_operation = op;
    while (!req_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: req_ready got 0 expected 1 after %0d cycles", waited);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e = model(a, b, op);
    e.acc = cyc;
    sb.push_back(e);
    req_valid = 1'b0;
    a_in = {$urandom, $urandom};
    b_in = {$urandom, $urandom};
    alu_operation = 3'($urandom);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_resp = 1'b0;
    end else if (resp_valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL stale_resp: resp_valid got 1 expected 0 (result %h)", result);
      end else begin
        mon_e = sb[0];
        if (!in_resp) begin
          check("latency", W'(cyc - mon_e.acc), W'(mon_e.lat));
          in_resp = 1'b1;
        end
        check("result", result, mon_e.res);
        check("remainder", remainder, mon_e.rem);
        check("zero", W'(zero), W'(mon_e.z));
        check("err", W'(err), W'(mon_e.e));
        check("req_ready_in_done", W'(req_ready), '0);
        if (resp_ready) begin
          void'(sb.pop_front());
          in_resp = 1'b0;
        end
      end
    end
  end

  initial begin
    int unsigned guard;
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    int unsigned  k;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", W'(req_ready), W'(1));
    check("rst_resp_valid", W'(resp_valid), '0);
    check("rst_result", result, '0);
    check("rst_remainder", remainder, '0);
    check("rst_zero", W'(zero), '0);
    check("rst_err", W'(err), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Add with the consumer stalled for several cycles.
    hold = 1'b1;
    issue(64'd5, 64'd6, 3'b010);
    repeat (4) @(negedge clk);
    hold = 1'b0;

    issue(64'd10, 64'd7, 3'b001);
    issue(64'd7, 64'd7, 3'b001);
    issue(64'd8, 64'd7, 3'b100);
    issue(64'h8000_0000_0000_0000, 64'd2, 3'b100);
    issue(64'd40, 64'd8, 3'b011);
    issue(64'd41, 64'd8, 3'b011);
    issue(64'd9, 64'd0, 3'b011);
    issue(64'd3, 64'd4, 3'b111);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
    issue(64'd0, 64'd1, 3'b001);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011);
    issue(64'd3, 64'd17, 3'b011);

    for (int i = 0; i < 40; i++) begin
      k   = $urandom_range(0, 9);
      rop = (k < 3) ? 3'b010 : (k < 5) ? 3'b001 : (k < 7) ? 3'b100 :
            (k < 9) ? 3'b011 : 3'($urandom);
      ra  = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 255)) : {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = W'($urandom_range(0, 15));
        1: rb = ra;
        default: rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      issue(ra, rb, rop);
    end

    // Reset in the middle of a multiply discards it.
    issue(64'd8, 64'd7, 3'b100);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_req_ready", W'(req_ready), W'(1));
    check("async_rst_resp_valid", W'(resp_valid), '0);
    check("async_rst_result", result, '0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(64'd1, 64'd1, 3'b010);

    guard = 0;
    while (sb.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: pending responses got %0d expected 0", sb.size());
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
